// File: rtl/clock_pkg.sv
// Shared timekeeping definitions: alarm FSM encoding, BCD field limits and edit-highlight codes.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    ARMED    = 3'd3,
    RINGING  = 3'd4,
    SNOOZE   = 3'd5
  } alarm_state_t;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;

  localparam logic [1:0] EDIT_NONE = 2'b00;
  localparam logic [1:0] EDIT_HOUR = 2'b01;
  localparam logic [1:0] EDIT_MIN  = 2'b10;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Combinational 8-bit BCD increment that wraps to 00 after MAX.
module bcd_wrap_inc #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] d,
  output logic [7:0] q
);

  // Anything at or beyond MAX (including malformed BCD) folds back to 00.
  always_comb begin
    if (d >= MAX)            q = 8'h00;
    else if (d[3:0] >= 4'd9) q = {d[7:4] + 4'd1, 4'h0};
    else                     q = d + 8'd1;
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: stores HH:MM, rings on HH:MM:00, cleared by btn_mode or timeout.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300,
  parameter logic [7:0]  RST_HOUR       = 8'h07,
  parameter logic [7:0]  RST_MIN        = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       blink,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic [1:0] edit_field,
  output logic       alarm_armed,
  output logic       alarm_ringing,
  output logic [7:0] alarm_led
);

  if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring
    $error("RING_SECONDS out of range");
  end
  if (SNOOZE_SECONDS < 1 || SNOOZE_SECONDS > 1023) begin : g_bad_snooze
    $error("SNOOZE_SECONDS out of range");
  end

  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

  alarm_state_t  state_q, state_d;
  logic [7:0]    ah_d, am_d, ah_inc, am_inc;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          match, match_q, match_rise;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECONDS - 1);
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`endif

  bcd_wrap_inc #(.MAX(BCD_HOUR_MAX)) u_hour_inc (.d(alarm_hour), .q(ah_inc));
  bcd_wrap_inc #(.MAX(BCD_MIN_MAX))  u_min_inc  (.d(alarm_min),  .q(am_inc));

  // Edge on match gives one trigger per minute, so a dismiss during :00 cannot re-ring.
  assign match      = (hour == alarm_hour) && (minute == alarm_min) && (second == 8'h00);
  assign match_rise = match & ~match_q;

  always_comb begin
    state_d    = state_q;
    ah_d       = alarm_hour;
    am_d       = alarm_min;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      IDLE:     if (btn_mode) state_d = SET_HOUR;
      SET_HOUR: if (btn_mode) state_d = SET_MIN;
                else if (btn_inc) ah_d = ah_inc;
      SET_MIN:  if (btn_mode) state_d = ARMED;
                else if (btn_inc) am_d = am_inc;
      ARMED: begin
        if (btn_mode) state_d = IDLE;
        else if (match_rise) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (btn_mode) state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
        else if (btn_inc) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
        end
`endif
        else if (tick_1hz) begin
          if (ring_cnt_q == RING_LAST) state_d = ARMED;
          else ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (btn_mode) state_d = ARMED;
        else if (tick_1hz) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else snz_cnt_d = snz_cnt_q + SW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      alarm_hour    <= RST_HOUR;
      alarm_min     <= RST_MIN;
      ring_cnt_q    <= '0;
      match_q       <= 1'b0;
      edit_field    <= EDIT_NONE;
      alarm_armed   <= 1'b0;
      alarm_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      alarm_hour    <= ah_d;
      alarm_min     <= am_d;
      ring_cnt_q    <= ring_cnt_d;
      match_q       <= match;
      edit_field    <= (state_d == SET_HOUR) ? EDIT_HOUR :
                       (state_d == SET_MIN)  ? EDIT_MIN  : EDIT_NONE;
      alarm_armed   <= (state_d == ARMED) || (state_d == RINGING) || (state_d == SNOOZE);
      alarm_ringing <= (state_d == RINGING);
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q     <= snz_cnt_d;
`endif
    end
  end

  assign alarm_led = (state_q == RINGING) ? {8{blink}} : 8'h00;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench: driver pushes model-predicted outputs per clk, monitor pops and compares.
module tb_alarm_controller;

  localparam int RS = 3;
  localparam int SS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_SETH = 1, P_SETM = 2, P_ARMED = 3, P_RING = 4, P_SNZ = 5;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, blink = 1'b0, bm = 1'b0, bi = 1'b0;
  logic [7:0] hour, minute, second;
  logic [7:0] alarm_hour, alarm_min, alarm_led;
  logic [1:0] edit_field;
  logic       alarm_armed, alarm_ringing;

  alarm_controller #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SS)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick), .blink(blink),
    .hour(hour), .minute(minute), .second(second),
    .btn_mode(bm), .btn_inc(bi),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .edit_field(edit_field),
    .alarm_armed(alarm_armed), .alarm_ringing(alarm_ringing), .alarm_led(alarm_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ah, am, led;
    logic [1:0] ef;
    logic       armed, ringing;
  } exp_t;

  exp_t sb[$];
  int total = 0, passed = 0;

  // Reference model in decimal integers.
  int m_phase, m_ah, m_am, m_rc, m_sc;
  bit m_prev;
  int th = 12, tm = 0, ts = 30;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("alarm_hour", alarm_hour, e.ah);
      chk("alarm_min", alarm_min, e.am);
      chk("edit_field", {6'd0, edit_field}, {6'd0, e.ef});
      chk("alarm_armed", {7'd0, alarm_armed}, {7'd0, e.armed});
      chk("alarm_ringing", {7'd0, alarm_ringing}, {7'd0, e.ringing});
      chk("alarm_led", alarm_led, e.led);
    end
  end

  task automatic step();
    bit match, rise;
    exp_t e;
    hour = bcd(th); minute = bcd(tm); second = bcd(ts);
    if (!rst) begin
      m_phase = P_IDLE; m_ah = 7; m_am = 0; m_rc = 0; m_sc = 0; m_prev = 0;
    end else begin
      match  = (th == m_ah) && (tm == m_am) && (ts == 0);
      rise   = match && !m_prev;
      m_prev = match;
      case (m_phase)
        P_IDLE:  if (bm) m_phase = P_SETH;
        P_SETH:  if (bm) m_phase = P_SETM; else if (bi) m_ah = (m_ah + 1) % 24;
        P_SETM:  if (bm) m_phase = P_ARMED; else if (bi) m_am = (m_am + 1) % 60;
        P_ARMED: if (bm) m_phase = P_IDLE; else if (rise) begin m_phase = P_RING; m_rc = 0; end
        P_RING: begin
          if (bm) m_phase = P_ARMED;
          else if (SNZ_EN && bi) begin m_phase = P_SNZ; m_sc = 0; end
          else if (tick) begin
            m_rc++;
            if (m_rc == RS) m_phase = P_ARMED;
          end
        end
        default: begin
          if (bm) m_phase = P_ARMED;
          else if (tick) begin
            m_sc++;
            if (m_sc == SS) begin m_phase = P_RING; m_rc = 0; end
          end
        end
      endcase
    end
    e.ah      = bcd(m_ah);
    e.am      = bcd(m_am);
    e.ef      = (m_phase == P_SETH) ? 2'b01 : (m_phase == P_SETM) ? 2'b10 : 2'b00;
    e.armed   = (m_phase >= P_ARMED);
    e.ringing = (m_phase == P_RING);
    e.led     = (m_phase == P_RING) ? {8{blink}} : 8'h00;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    bm = 1'b0; bi = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic press_mode(); bm = 1'b1; step(); step(); endtask
  task automatic press_inc(input int n);
    repeat (n) begin bi = 1'b1; step(); end
  endtask
  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s; step();
  endtask
  task automatic do_ticks(input int n);
    repeat (n) begin tick = 1'b1; step(); step(); end
  endtask

  initial begin
    idle(3);
    rst = 1'b1;
    idle(2);

    // Program alarm 09:05 and arm.
    press_mode(); press_inc(2);
    press_mode(); press_inc(5);
    press_mode(); idle(2);

    // Ring at 09:05:00, led follows blink.
    set_time(9, 4, 59);
    tick = 1'b1; set_time(9, 5, 0);
    repeat (4) begin blink = ~blink; step(); end

    // Dismiss during :00, no re-ring; ring again next day.
    press_mode(); idle(3);
    set_time(9, 5, 1); set_time(9, 4, 59); set_time(9, 5, 0);

    // Timeout on third tick.
    idle(1); do_ticks(RS); idle(2);

    // Snooze (or ignored inc), then timeout/dismiss.
    set_time(9, 5, 1); set_time(9, 5, 0);
    blink = 1'b1; press_inc(1); idle(1);
    do_ticks(SS); idle(1);
    press_mode(); idle(1);

    // Reset mid-ring.
    set_time(9, 5, 1); set_time(9, 5, 0); idle(1);
    rst = 1'b0; idle(2); rst = 1'b1; idle(2);

    // Wraps and simultaneous buttons; edit across alarm time; arm while matched.
    press_mode(); press_inc(16); press_inc(1);
    bm = 1'b1; bi = 1'b1; step();
    press_inc(59); idle(1); press_inc(1);
    set_time(0, 0, 0); idle(2);
    press_mode(); idle(3);
    set_time(0, 0, 1); set_time(0, 0, 0); idle(2); press_mode();

    // Randomized traffic biased toward the alarm time.
    repeat (2500) begin
      int r;
      bm   = ($urandom_range(0, 15) == 0);
      bi   = ($urandom_range(0, 7) == 0);
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) blink = ~blink;
      r = $urandom_range(0, 9);
      if (r >= 7) begin
        th = $urandom_range(0, 23); tm = $urandom_range(0, 59); ts = $urandom_range(0, 59);
      end else if (r >= 4) begin
        th = m_ah; tm = m_am; ts = $urandom_range(0, 1) ? 0 : $urandom_range(0, 59);
      end
      step();
    end

    idle(2);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
